spi_cmd_decoder: RTL and testbench

- Byte-level command parser between the SPI slave byte receiver (upstream) and the discharge pulse generator / waveform controller (downstream) inside fpga_slave.
- Consumes received bytes, assembles opcode plus little-endian operands, and publishes machining parameters (Ton, Toff, waveform, Ip) with start/stop pulses.
- Serves the 4-byte feedback readback by loading MISO bytes into the SPI transmitter.

---
 rtl/spi_cmd_decoder.sv | 178 +++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// SPI command byte parser: opcode + little-endian 16-bit operands into machining
// parameters, start/stop pulses and 4-byte feedback readback. Option: PARAM_RANGE_CHECK_EN.
module spi_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TON_MIN        = 1,
  parameter int TON_MAX        = 1000
) (
  input  logic        clk_in,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [31:0] feedback_word,
  output logic [7:0]  tx_data,
  output logic        tx_load,
  output logic [15:0] ton_us,
  output logic [15:0] toff_us,
  output logic [15:0] waveform,
  output logic [15:0] ip_set,
  output logic        param_update,
  output logic        machine_start,
  output logic        machine_stop,
  output logic        cmd_error
);
  typedef enum logic [1:0] {IDLE, OP_LO, OP_HI, FB_TX} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_op, w_op_nxt, r_lo, w_lo_nxt;
  logic [31:0]   r_shadow, w_shadow_nxt;
  logic [2:0]    r_bcnt, w_bcnt_nxt;
  logic [TW-1:0] r_tmo;
  logic [15:0]   r_ton, r_toff, r_wave, r_ip;
  logic [15:0]   w_ton_nxt, w_toff_nxt, w_wave_nxt, w_ip_nxt;
  logic [7:0]    r_tx, w_tx_nxt;
  logic          r_load, r_pu, r_start, r_stop, r_err;
  logic          w_load_nxt, w_pu_nxt, w_start_nxt, w_stop_nxt, w_err_nxt;
  logic          w_timeout, w_time_ok, w_ip_ok, w_wave_ok;
  logic [15:0]   w_operand;

  assign w_operand = {rx_data, r_lo};
  assign w_timeout = (r_state != IDLE) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_wave_ok = (w_operand == 16'h8000) || (w_operand == 16'h2001) ||
                     (w_operand == 16'h2002) || (w_operand == 16'h6001) ||
                     (w_operand == 16'h4001);
`ifdef PARAM_RANGE_CHECK_EN
  assign w_time_ok = (w_operand >= 16'(TON_MIN)) && (w_operand <= 16'(TON_MAX));
  assign w_ip_ok   = (w_operand <= 16'd200);
`else
  assign w_time_ok = 1'b1;
  assign w_ip_ok   = 1'b1;
`endif

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_lo     <= '0;
      r_shadow <= '0;
      r_bcnt   <= '0;
      r_tmo    <= '0;
      r_ton    <= 16'd100;
      r_toff   <= 16'd50;
      r_wave   <= 16'h8000;
      r_ip     <= '0;
      r_tx     <= '0;
      r_load   <= 1'b0;
      r_pu     <= 1'b0;
      r_start  <= 1'b0;
      r_stop   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_lo     <= w_lo_nxt;
      r_shadow <= w_shadow_nxt;
      r_bcnt   <= w_bcnt_nxt;
      // Inter-byte watchdog only runs while a command is in flight
      if (r_state == IDLE || rx_valid || w_timeout) r_tmo <= '0;
      else                                          r_tmo <= r_tmo + 1'b1;
      r_ton    <= w_ton_nxt;
      r_toff   <= w_toff_nxt;
      r_wave   <= w_wave_nxt;
      r_ip     <= w_ip_nxt;
      r_tx     <= w_tx_nxt;
      r_load   <= w_load_nxt;
      r_pu     <= w_pu_nxt;
      r_start  <= w_start_nxt;
      r_stop   <= w_stop_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_lo_nxt     = r_lo;
    w_shadow_nxt = r_shadow;
    w_bcnt_nxt   = r_bcnt;
    w_ton_nxt    = r_ton;
    w_toff_nxt   = r_toff;
    w_wave_nxt   = r_wave;
    w_ip_nxt     = r_ip;
    w_tx_nxt     = r_tx;
    w_err_nxt    = r_err;
    w_load_nxt   = 1'b0;
    w_pu_nxt     = 1'b0;
    w_start_nxt  = 1'b0;
    w_stop_nxt   = 1'b0;
    // Timeout takes priority; a byte arriving on that cycle is dropped
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_err_nxt   = 1'b1;
      w_tx_nxt    = 8'h00;
    end else if (rx_valid) begin
      case (r_state)
        IDLE: begin
          case (rx_data)
            8'h91, 8'h9E, 8'h9C, 8'h93: begin
              w_op_nxt    = rx_data;
              w_state_nxt = OP_LO;
            end
            8'h06: w_start_nxt = 1'b1;
            8'h07: w_stop_nxt  = 1'b1;
            8'h0F: w_err_nxt   = 1'b0;
            8'hAB: begin
              w_shadow_nxt = feedback_word;
              w_tx_nxt     = feedback_word[7:0];
              w_load_nxt   = 1'b1;
              w_bcnt_nxt   = 3'd1;
              w_state_nxt  = FB_TX;
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
        OP_LO: begin
          w_lo_nxt    = rx_data;
          w_state_nxt = OP_HI;
        end
        OP_HI: begin
          w_state_nxt = IDLE;
          case (r_op)
            8'h91: if (w_time_ok) begin w_ton_nxt  = w_operand; w_pu_nxt = 1'b1; end
                   else w_err_nxt = 1'b1;
            8'h9E: if (w_time_ok) begin w_toff_nxt = w_operand; w_pu_nxt = 1'b1; end
                   else w_err_nxt = 1'b1;
            8'h9C: if (w_wave_ok) begin w_wave_nxt = w_operand; w_pu_nxt = 1'b1; end
                   else w_err_nxt = 1'b1;
            8'h93: if (w_ip_ok)   begin w_ip_nxt   = w_operand; w_pu_nxt = 1'b1; end
                   else w_err_nxt = 1'b1;
            default: w_err_nxt = 1'b1;
          endcase
        end
        FB_TX: begin
          if (r_bcnt == 3'd4) begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 8'h00;
          end else begin
            w_tx_nxt   = r_shadow[8*r_bcnt[1:0] +: 8];
            w_load_nxt = 1'b1;
            w_bcnt_nxt = r_bcnt + 3'd1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign tx_data       = r_tx;
  assign tx_load       = r_load;
  assign ton_us        = r_ton;
  assign toff_us       = r_toff;
  assign waveform      = r_wave;
  assign ip_set        = r_ip;
  assign param_update  = r_pu;
  assign machine_start = r_start;
  assign machine_stop  = r_stop;
  assign cmd_error     = r_err;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder (short timeout for speed).
module tb_spi_cmd_decoder;
  localparam int TMO = 200;

  logic        clk_in = 1'b0;
  logic        sys_rst, rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] feedback_word;
  logic [7:0]  tx_data;
  logic        tx_load, param_update, machine_start, machine_stop, cmd_error;
  logic [15:0] ton_us, toff_us, waveform, ip_set;

  spi_cmd_decoder #(.TIMEOUT_CYCLES(TMO), .TON_MIN(1), .TON_MAX(1000)) dut (
    .clk_in(clk_in), .sys_rst(sys_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .feedback_word(feedback_word), .tx_data(tx_data), .tx_load(tx_load),
    .ton_us(ton_us), .toff_us(toff_us), .waveform(waveform), .ip_set(ip_set),
    .param_update(param_update), .machine_start(machine_start),
    .machine_stop(machine_stop), .cmd_error(cmd_error));

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_pass = 0;
  int n_pu = 0, n_start = 0, n_stop = 0, n_load = 0;
  logic [7:0] ld [8];

  // Pulse counters sampled away from the active edge
  always @(negedge clk_in) begin
    if (!sys_rst) begin
      if (param_update)  n_pu++;
      if (machine_start) n_start++;
      if (machine_stop)  n_stop++;
      if (tx_load) begin
        if (n_load < 8) ld[n_load] = tx_data;
        n_load++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_in);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_in);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic cmd3(input logic [7:0] op, input logic [7:0] lo, input logic [7:0] hi);
    send(op); send(lo); send(hi);
  endtask

  int pu0, st0;
  logic [15:0] ton0;

  initial begin
    sys_rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; feedback_word = '0;
    idle(3);
    sys_rst = 1'b0;
    idle(1);
    chk("rst_ton", ton_us, 16'd100);
    chk("rst_toff", toff_us, 16'd50);
    chk("rst_wave", waveform, 16'h8000);
    chk("rst_ip", ip_set, 16'd0);
    chk("rst_tx", tx_data, 8'h00);
    chk("rst_strobes", {tx_load, param_update, machine_start, machine_stop, cmd_error}, 5'b0);

    // Ton writes, one-cycle latency and exactly one pulse each
    pu0 = n_pu;
    cmd3(8'h91, 8'hE8, 8'h03);
    chk("ton_1000", ton_us, 16'd1000);
    chk("pu_latency", param_update, 1'b1);
    cmd3(8'h91, 8'h64, 8'h00);
    idle(2);
    chk("ton_100", ton_us, 16'd100);
    chk("pu_count_ton", n_pu - pu0, 2);

    cmd3(8'h9E, 8'hF4, 8'h01);
    chk("toff_500", toff_us, 16'd500);
    cmd3(8'h9E, 8'h32, 8'h00);
    chk("toff_50", toff_us, 16'd50);

    // Waveform accept / reject
    cmd3(8'h9C, 8'h01, 8'h60);
    idle(2);
    chk("wave_6001", waveform, 16'h6001);
    pu0 = n_pu;
    cmd3(8'h9C, 8'h34, 8'h12);
    idle(2);
    chk("wave_rej_val", waveform, 16'h6001);
    chk("wave_rej_err", cmd_error, 1'b1);
    chk("wave_rej_pu", n_pu - pu0, 0);
    send(8'h0F);
    chk("err_clear", cmd_error, 1'b0);

    // Ip then start / stop
    cmd3(8'h93, 8'h3C, 8'h00);
    chk("ip_60", ip_set, 16'd60);
    st0 = n_start;
    send(8'h06);
    idle(3);
    chk("start_once", n_start - st0, 1);
    send(8'h07);
    idle(3);
    chk("stop_once", n_stop, 1);

    // Unknown opcode, then opcodes inside an operand are just data
    send(8'h55);
    chk("unknown_err", cmd_error, 1'b1);
    send(8'h0F);
    st0 = n_start;
    cmd3(8'h91, 8'h06, 8'h00);
    idle(2);
    chk("midcmd_ton", ton_us, 16'd6);
    chk("midcmd_nostart", n_start - st0, 0);

    // Feedback readback from shadow copy
    feedback_word = 32'hDEADBEEF;
    n_load = 0;
    send(8'hAB);
    feedback_word = 32'h12345678;
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
    idle(2);
    chk("fb_nload", n_load, 4);
    chk("fb_b0", ld[0], 8'hEF);
    chk("fb_b1", ld[1], 8'hBE);
    chk("fb_b2", ld[2], 8'hAD);
    chk("fb_b3", ld[3], 8'hDE);
    chk("fb_txzero", tx_data, 8'h00);
    chk("fb_noerr", cmd_error, 1'b0);
    st0 = n_start;
    send(8'h06);
    idle(2);
    chk("fb_idle", n_start - st0, 1);

    // Inter-byte timeout
    send(8'h91); send(8'h10);
    idle(TMO - 10);
    chk("tmo_early", cmd_error, 1'b0);
    idle(20);
    chk("tmo_err", cmd_error, 1'b1);
    chk("tmo_ton", ton_us, 16'd6);
    st0 = n_start;
    send(8'h06);
    idle(2);
    chk("tmo_opcode", n_start - st0, 1);
    send(8'h0F);

    // Reset mid-command
    send(8'h91); send(8'h22);
    @(negedge clk_in); sys_rst = 1'b1;
    idle(2);
    sys_rst = 1'b0;
    idle(1);
    chk("rstmid_ton", ton_us, 16'd100);
    chk("rstmid_ip", ip_set, 16'd0);
    send(8'h00);
    chk("rstmid_idle", cmd_error, 1'b1);
    send(8'h0F);

    // Ton of zero: range-check option decides
    pu0 = n_pu;
    cmd3(8'h91, 8'h00, 8'h00);
    idle(2);
`ifdef PARAM_RANGE_CHECK_EN
    chk("range_ton", ton_us, 16'd100);
    chk("range_err", cmd_error, 1'b1);
    chk("range_pu", n_pu - pu0, 0);
`else
    chk("range_ton", ton_us, 16'd0);
    chk("range_err", cmd_error, 1'b0);
    chk("range_pu", n_pu - pu0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
